// File: rtl/ysyx_25020037_axi_arbiter.sv
// ysyx_25020037_axi_arbiter
// Two-master, one-slave AXI4 arbiter placed between the IFU (m0, read-only)
// and the LSU (m1, read/write) and the SoC crossbar. Only one whole
// transaction (AR+R burst or AW+W+B) is in flight on the slave port at a time.
// The LSU has fixed priority. A starvation counter forces an IFU grant after
// STARVE_LIMIT LSU grants that were issued while the IFU was waiting.
// Routing is purely combinational from the grant state, so the arbiter holds
// no data registers and never creates or drops a handshake.
module ysyx_25020037_axi_arbiter #(
  parameter int STARVE_LIMIT = 4  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  // IFU read-only master
  input  logic        m0_arvalid,
  output logic        m0_arready,
  input  logic [48:0] m0_ar,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  output logic [38:0] m0_r,
  // LSU read/write master
  input  logic        m1_arvalid,
  output logic        m1_arready,
  input  logic [48:0] m1_ar,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [38:0] m1_r,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [48:0] m1_aw,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  input  logic [36:0] m1_w,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  output logic [5:0]  m1_b,
  // shared slave port
  output logic        s_arvalid,
  input  logic        s_arready,
  output logic [48:0] s_ar,
  input  logic        s_rvalid,
  output logic        s_rready,
  input  logic [38:0] s_r,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [48:0] s_aw,
  output logic        s_wvalid,
  input  logic        s_wready,
  output logic [36:0] s_w,
  input  logic        s_bvalid,
  output logic        s_bready,
  input  logic [5:0]  s_b
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  // rlast position inside the {rdata,rresp,rlast,rid} bundle
  localparam int RLAST_BIT = 4;

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [3:0] lsu_grant_cnt_s;

  // grant state and starvation counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // counter value to load when the LSU is granted: count only grants that
  // overtook a waiting IFU, saturating at the limit
  always_comb begin
    lsu_grant_cnt_s = 4'd0;
    if (m0_arvalid) begin
      if (starve_cnt_q >= LIMIT) begin
        lsu_grant_cnt_s = LIMIT;
      end else begin
        lsu_grant_cnt_s = starve_cnt_q + 4'd1;
      end
    end else begin
      lsu_grant_cnt_s = 4'd0;
    end
  end

  // arbitration in IDLE and end-of-transaction detection in the grant states
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_arvalid && (starve_cnt_q == LIMIT)) begin
          state_d      = RD_IFU;
          starve_cnt_d = 4'd0;
        end else if (m1_awvalid) begin
          state_d      = WR_LSU;
          starve_cnt_d = lsu_grant_cnt_s;
        end else if (m1_arvalid) begin
          state_d      = RD_LSU;
          starve_cnt_d = lsu_grant_cnt_s;
        end else if (m0_arvalid) begin
          state_d      = RD_IFU;
          starve_cnt_d = 4'd0;
        end else begin
          state_d      = IDLE;
        end
      end
      RD_IFU: begin
        if (s_rvalid && m0_rready && s_r[RLAST_BIT]) begin
          state_d = IDLE;
        end else begin
          state_d = RD_IFU;
        end
      end
      RD_LSU: begin
        if (s_rvalid && m1_rready && s_r[RLAST_BIT]) begin
          state_d = IDLE;
        end else begin
          state_d = RD_LSU;
        end
      end
      WR_LSU: begin
        if (s_bvalid && m1_bready) begin
          state_d = IDLE;
        end else begin
          state_d = WR_LSU;
        end
      end
      default: begin
        state_d      = IDLE;
        starve_cnt_d = 4'd0;
      end
    endcase
  end

  // channel routing: only the granted master's channels are connected,
  // everything else is held at zero
  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_r       = 39'd0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_r       = 39'd0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_b       = 6'd0;
    s_arvalid  = 1'b0;
    s_ar       = 49'd0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_aw       = 49'd0;
    s_wvalid   = 1'b0;
    s_w        = 37'd0;
    s_bready   = 1'b0;
    case (state_q)
      RD_IFU: begin
        s_arvalid  = m0_arvalid;
        s_ar       = m0_ar;
        m0_arready = s_arready;
        m0_rvalid  = s_rvalid;
        m0_r       = s_r;
        s_rready   = m0_rready;
      end
      RD_LSU: begin
        s_arvalid  = m1_arvalid;
        s_ar       = m1_ar;
        m1_arready = s_arready;
        m1_rvalid  = s_rvalid;
        m1_r       = s_r;
        s_rready   = m1_rready;
      end
      WR_LSU: begin
        s_awvalid  = m1_awvalid;
        s_aw       = m1_aw;
        m1_awready = s_awready;
        s_wvalid   = m1_wvalid;
        s_w        = m1_w;
        m1_wready  = s_wready;
        m1_bvalid  = s_bvalid;
        m1_b       = s_b;
        s_bready   = m1_bready;
      end
      IDLE: begin
        s_arvalid  = 1'b0;
      end
      default: begin
        s_arvalid  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Directed testbench for ysyx_25020037_axi_arbiter (STARVE_LIMIT = 4).
// The bench plays both masters and the slave. Inputs change 1 time unit
// after the rising edge, and outputs are sampled on the falling edge.
module tb_ysyx_25020037_axi_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [48:0] m0_ar;
  logic [38:0] m0_r;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [48:0] m1_ar;
  logic [38:0] m1_r;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [48:0] m1_aw;
  logic [36:0] m1_w;
  logic [5:0]  m1_b;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [48:0] s_ar;
  logic [38:0] s_r;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [48:0] s_aw;
  logic [36:0] s_w;
  logic [5:0]  s_b;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_25020037_axi_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_ar(m0_ar),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_r(m0_r),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_ar(m1_ar),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_r(m1_r),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_aw(m1_aw),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_w(m1_w),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_b(m1_b),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] mk_ar(input logic [31:0] addr, input logic [3:0] id,
                                        input logic [7:0] len);
    return {addr, id, len, 3'd2, 2'd1};
  endfunction

  function automatic logic [38:0] mk_r(input logic [31:0] data, input logic last,
                                       input logic [3:0] id);
    return {data, 2'b00, last, id};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    m0_arvalid = 1'b0; m0_ar = 49'd0; m0_rready = 1'b0;
    m1_arvalid = 1'b0; m1_ar = 49'd0; m1_rready = 1'b0;
    m1_awvalid = 1'b0; m1_aw = 49'd0; m1_wvalid = 1'b0; m1_w = 37'd0; m1_bready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_r = 39'd0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_b = 6'd0;
  endtask

  // every valid/ready output low and every data bundle zero
  task automatic check_idle(input string tag);
    check_eq({tag, "_vr"}, {52'd0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                            m0_arready, m1_arready, m1_awready, m1_wready,
                            m0_rvalid, m1_rvalid, m1_bvalid}, 64'd0);
    check_eq({tag, "_data"}, {63'd0, |{s_ar, s_aw, s_w, m0_r, m1_r, m1_b}}, 64'd0);
  endtask

  // Serves a single-beat read; entered at the start of the first granted cycle.
  task automatic serve_read(input logic ifu, input logic [48:0] ar, input logic [38:0] r);
    s_arready = 1'b1;
    @(negedge clk);
    check_eq("rd_s_arvalid", {63'd0, s_arvalid}, 64'd1);
    check_eq("rd_s_ar", {15'd0, s_ar}, {15'd0, ar});
    check_eq("rd_arready_granted", {63'd0, ifu ? m0_arready : m1_arready}, 64'd1);
    check_eq("rd_arready_other", {63'd0, ifu ? m1_arready : m0_arready}, 64'd0);
    next_cycle();
    s_arready = 1'b0;
    if (ifu) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
    s_rvalid = 1'b1; s_r = r;
    m0_rready = ifu; m1_rready = ~ifu;
    @(negedge clk);
    check_eq("rd_rvalid_granted", {63'd0, ifu ? m0_rvalid : m1_rvalid}, 64'd1);
    check_eq("rd_r_granted", {25'd0, ifu ? m0_r : m1_r}, {25'd0, r});
    check_eq("rd_rvalid_other", {63'd0, ifu ? m1_rvalid : m0_rvalid}, 64'd0);
    check_eq("rd_r_other", {25'd0, ifu ? m1_r : m0_r}, 64'd0);
    next_cycle();
    s_rvalid = 1'b0; s_r = 39'd0; m0_rready = 1'b0; m1_rready = 1'b0;
  endtask

  logic [48:0] ar_ifu;
  logic [48:0] ar_lsu;
  logic [48:0] aw_lsu;
  logic [36:0] w_lsu;

  initial begin
    rst = 1'b1;
    clr_inputs();
    // junk on the inputs must not leak out while in reset
    m0_ar = mk_ar(32'h1111_1111, 4'h1, 8'd0);
    s_r   = mk_r(32'h2222_2222, 1'b1, 4'h2);
    s_b   = 6'h3F;
    next_cycle();
    @(negedge clk);
    check_idle("reset");
    next_cycle();
    rst = 1'b0;
    clr_inputs();

    // single IFU read, addr 0x3000_0000, data 0xDEADBEEF
    ar_ifu = mk_ar(32'h3000_0000, 4'h1, 8'd0);
    m0_arvalid = 1'b1; m0_ar = ar_ifu;
    @(negedge clk);
    check_eq("ifu_arb_cycle_s_arvalid", {63'd0, s_arvalid}, 64'd0);
    next_cycle();
    serve_read(1'b1, ar_ifu, mk_r(32'hDEAD_BEEF, 1'b1, 4'h1));
    @(negedge clk);
    check_idle("ifu_done");
    next_cycle();

    // simultaneous IFU/LSU reads: LSU first, IFU in the IDLE cycle after rlast
    ar_lsu = mk_ar(32'h8000_0010, 4'h2, 8'd0);
    m0_arvalid = 1'b1; m0_ar = ar_ifu;
    m1_arvalid = 1'b1; m1_ar = ar_lsu;
    next_cycle();
    serve_read(1'b0, ar_lsu, mk_r(32'h0BAD_F00D, 1'b1, 4'h2));
    @(negedge clk);
    check_eq("both_idle_after_lsu", {63'd0, s_arvalid}, 64'd0);
    next_cycle();
    serve_read(1'b1, ar_ifu, mk_r(32'h1234_0000, 1'b1, 4'h1));

    // write and read together: write completes through B, then the read
    aw_lsu = mk_ar(32'hA000_0004, 4'h3, 8'd0);
    w_lsu  = {32'h5566_7788, 4'b1100, 1'b1};
    m1_awvalid = 1'b1; m1_aw = aw_lsu;
    m1_arvalid = 1'b1; m1_ar = ar_lsu;
    next_cycle();
    s_awready = 1'b1; m1_wvalid = 1'b1; m1_w = w_lsu;
    @(negedge clk);
    check_eq("wr_s_awvalid", {63'd0, s_awvalid}, 64'd1);
    check_eq("wr_s_aw", {15'd0, s_aw}, {15'd0, aw_lsu});
    check_eq("wr_awready", {63'd0, m1_awready}, 64'd1);
    check_eq("wr_s_w", {27'd0, s_w}, {27'd0, w_lsu});
    check_eq("wr_wready_held", {63'd0, m1_wready}, 64'd0);
    check_eq("wr_read_blocked", {62'd0, s_arvalid, m1_arready}, 64'd0);
    next_cycle();
    m1_awvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b1;
    @(negedge clk);
    check_eq("wr_wready", {63'd0, m1_wready}, 64'd1);
    check_eq("wr_s_awvalid_done", {63'd0, s_awvalid}, 64'd0);
    next_cycle();
    m1_wvalid = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_b = {2'b10, 4'h3}; m1_bready = 1'b1;
    @(negedge clk);
    check_eq("wr_bvalid", {63'd0, m1_bvalid}, 64'd1);
    check_eq("wr_b_slverr", {58'd0, m1_b}, 64'h23);
    check_eq("wr_s_bready", {63'd0, s_bready}, 64'd1);
    next_cycle();
    s_bvalid = 1'b0; s_b = 6'd0; m1_bready = 1'b0;
    @(negedge clk);
    check_idle("wr_done");
    next_cycle();
    serve_read(1'b0, ar_lsu, mk_r(32'hCAFE_0001, 1'b1, 4'h2));

    // starvation: 4 LSU grants while IFU waits, then IFU, then counter is 0
    m0_arvalid = 1'b1; m0_ar = ar_ifu;
    for (int i = 0; i < 4; i++) begin
      m1_arvalid = 1'b1; m1_ar = mk_ar(32'h8000_0100 + 32'(i * 4), 4'h2, 8'd0);
      @(negedge clk);
      check_eq("starve_idle", {63'd0, s_arvalid}, 64'd0);
      next_cycle();
      serve_read(1'b0, mk_ar(32'h8000_0100 + 32'(i * 4), 4'h2, 8'd0),
                 mk_r(32'h0000_0100 + 32'(i), 1'b1, 4'h2));
    end
    m1_arvalid = 1'b1; m1_ar = ar_lsu;
    next_cycle();
    serve_read(1'b1, ar_ifu, mk_r(32'h0000_0AAA, 1'b1, 4'h1));
    m0_arvalid = 1'b1;
    next_cycle();
    serve_read(1'b0, ar_lsu, mk_r(32'h0000_0BBB, 1'b1, 4'h2));
    next_cycle();
    serve_read(1'b1, ar_ifu, mk_r(32'h0000_0CCC, 1'b1, 4'h1));

    // 4-beat IFU burst with 2-cycle rvalid gaps; LSU waits for rlast
    m0_arvalid = 1'b1; m0_ar = mk_ar(32'h3000_0040, 4'h1, 8'd3);
    next_cycle();
    m1_arvalid = 1'b1; m1_ar = ar_lsu;
    s_arready = 1'b1;
    @(negedge clk);
    check_eq("burst_s_ar", {15'd0, s_ar}, {15'd0, mk_ar(32'h3000_0040, 4'h1, 8'd3)});
    next_cycle();
    s_arready = 1'b0; m0_arvalid = 1'b0; m0_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check_eq("burst_gap_lsu_blocked", {62'd0, s_arvalid, m1_arready}, 64'd0);
        next_cycle();
      end
      s_rvalid = 1'b1; s_r = mk_r(32'hB000_0000 + 32'(b), (b == 3), 4'h1);
      @(negedge clk);
      check_eq("burst_beat", {25'd0, m0_r}, {25'd0, mk_r(32'hB000_0000 + 32'(b), (b == 3), 4'h1)});
      check_eq("burst_beat_valid", {62'd0, m0_rvalid, m1_arready}, 64'd2);
      next_cycle();
    end
    s_rvalid = 1'b0; s_r = 39'd0; m0_rready = 1'b0;
    @(negedge clk);
    check_idle("burst_done");
    next_cycle();
    serve_read(1'b0, ar_lsu, mk_r(32'h0000_0DDD, 1'b1, 4'h2));

    // reset mid-RD_IFU
    m0_arvalid = 1'b1; m0_ar = ar_ifu;
    next_cycle();
    @(negedge clk);
    check_eq("pre_rst_s_arvalid", {63'd0, s_arvalid}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check_idle("rst_mid_ifu");
    next_cycle();
    rst = 1'b0;
    m0_arvalid = 1'b0;
    @(negedge clk);
    check_idle("rst_mid_ifu_after");
    next_cycle();

    // reset mid-RD_LSU with the counter at the limit clears the counter
    m0_arvalid = 1'b1; m0_ar = ar_ifu;
    for (int i = 0; i < 3; i++) begin
      m1_arvalid = 1'b1; m1_ar = ar_lsu;
      next_cycle();
      serve_read(1'b0, ar_lsu, mk_r(32'h0000_0E00 + 32'(i), 1'b1, 4'h2));
    end
    m1_arvalid = 1'b1;
    next_cycle();
    @(negedge clk);
    check_eq("rst_cnt_4th_lsu", {15'd0, s_ar}, {15'd0, ar_lsu});
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    next_cycle();
    serve_read(1'b0, ar_lsu, mk_r(32'h0000_0F00, 1'b1, 4'h2));
    next_cycle();
    serve_read(1'b1, ar_ifu, mk_r(32'h0000_0F01, 1'b1, 4'h1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_axi_arbiter.md
Name: ysyx_25020037_axi_arbiter

Overview:
- 2-master, 1-slave AXI4 arbiter. Shares the core's single memory-side AXI port between the IFU (m0, read-only) and the LSU (m1, read and write).
- Serialises whole transactions: exactly one outstanding transaction (AR+R burst, or AW+W+B) at a time across the slave port.
- Fixed LSU priority, plus an IFU anti-starvation counter. Sits between the IFU/LSU and the SoC crossbar.

Parameters:
- STARVE_LIMIT, 4: consecutive LSU grants issued while m0_arvalid is pending, after which the IFU gets the next grant. Legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  reset
m0_arvalid  in  1  IFU read-address valid
m0_arready  out  1  IFU read-address ready
m0_ar  in  49  IFU {araddr[31:0],arid[3:0],arlen[7:0],arsize[2:0],arburst[1:0]}
m0_rvalid  out  1  IFU read-data valid
m0_rready  in  1  IFU read-data ready
m0_r  out  39  IFU {rdata[31:0],rresp[1:0],rlast,rid[3:0]}
m1_arvalid  in  1  LSU read-address valid
m1_arready  out  1  LSU read-address ready
m1_ar  in  49  LSU read-address bundle, layout as m0_ar
m1_rvalid  out  1  LSU read-data valid
m1_rready  in  1  LSU read-data ready
m1_r  out  39  LSU read-data bundle, layout as m0_r
m1_awvalid  in  1  LSU write-address valid
m1_awready  out  1  LSU write-address ready
m1_aw  in  49  LSU {awaddr,awid,awlen,awsize,awburst}
m1_wvalid  in  1  LSU write-data valid
m1_wready  out  1  LSU write-data ready
m1_w  in  37  LSU {wdata[31:0],wstrb[3:0],wlast}
m1_bvalid  out  1  LSU write-response valid
m1_bready  in  1  LSU write-response ready
m1_b  out  6  LSU {bresp[1:0],bid[3:0]}
s_arvalid/s_arready/s_ar  out/in/out  1/1/49  slave AR channel
s_rvalid/s_rready/s_r  in/out/in  1/1/39  slave R channel
s_awvalid/s_awready/s_aw  out/in/out  1/1/49  slave AW channel
s_wvalid/s_wready/s_w  out/in/out  1/1/37  slave W channel
s_bvalid/s_bready/s_b  in/out/in  1/1/6  slave B channel

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, state=IDLE and starve_cnt=0. Every valid/ready output is therefore 0, and every output data bundle is 0.
- States: IDLE, RD_IFU, RD_LSU, WR_LSU (registered). All channel routing is combinational from state; no data registers.
- IDLE: all master readys and slave valids are 0. Arbitration order:
  - If m0_arvalid and starve_cnt==STARVE_LIMIT: go to RD_IFU.
  - Else if m1_awvalid: go to WR_LSU.
  - Else if m1_arvalid: go to RD_LSU.
  - Else if m0_arvalid: go to RD_IFU.
  - Arbitration costs exactly 1 cycle. Requests remain asserted per AXI rules, so nothing is latched.
- RD_x:
  - Pass through s_ar*/mx_arready and s_r*/mx_rready/mx_r to the granted master.
  - Non-granted master sees arready=0, rvalid=0, r bundle=0.
  - Return to IDLE on the cycle where s_rvalid & s_rready & rlast.
  - A slave rvalid with rlast=0 keeps the grant (multi-beat bursts supported).
- WR_LSU:
  - Pass through AW, W and B channels. AW and W are independent; either may complete first.
  - Return to IDLE on s_bvalid & s_bready.
  - All read channels are blocked during WR_LSU.
- Outside its own state, a channel's slave valid and master ready are forced to 0. The arbiter never creates or drops a handshake.
- starve_cnt (4 bits), updated on the transition out of IDLE:
  - LSU grant with m0_arvalid=1: saturating increment, capped at STARVE_LIMIT.
  - IFU grant: clear to 0.
  - LSU grant with m0_arvalid=0: clear to 0.
- Simultaneous m1_awvalid and m1_arvalid: the write wins; the read is served on the next arbitration.
- Reset mid-transaction: state returns to IDLE immediately. The slave transaction is abandoned; the SoC is reset concurrently.
- Slave error responses (rresp/bresp≠0) are forwarded unchanged and do not affect sequencing.

Test Plan:
- Reset mid-RD_IFU → next cycle all valid/ready outputs 0, state IDLE, starve_cnt 0.
- m0_arvalid alone, addr 0x3000_0000, single beat rdata 0xDEADBEEF → s_arvalid rises 1 cycle after the request; m0_r returns 0xDEADBEEF with rlast=1; m1_rvalid stays 0 throughout.
- m0_arvalid and m1_arvalid in the same cycle → LSU granted first; IFU granted in the IDLE cycle after the LSU's rlast.
- m1_awvalid and m1_arvalid together, awaddr 0xA000_0004, wstrb 0b1100 → write completes through B first, then the read is issued.
- LSU requests every cycle while the IFU holds m0_arvalid, STARVE_LIMIT=4 → exactly 4 LSU transactions, then the IFU is granted; starve_cnt returns to 0.
- 4-beat IFU burst (arlen=3) with rvalid gaps of 2 cycles → grant held until the 4th beat with rlast; LSU request waiting meanwhile is not granted early.
